// File: rtl/sum_byte_serializer_pkg.sv
// Shared definitions for the sum byte serializer.
// Holds the default word and byte widths, the values derived from them,
// and the serializer state encoding.
package sum_byte_serializer_pkg;

  localparam int SBS_DATA_W     = 32;
  localparam int SBS_BYTE_W     = 8;
  localparam int BYTES_PER_WORD = SBS_DATA_W / SBS_BYTE_W;
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/sum_byte_serializer_fifo.sv
// sum_word_fifo: synchronous FIFO that buffers completed sum words.
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   push, din         write din at the tail (ignored when full)
//   pop, dout         dout shows the head; pop advances it (ignored when empty)
//   count, full, empty occupancy status, all taken from registered state
module sum_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Explicit wrap so non-power-of-2 pointer widths (DEPTH=1) stay in range.
    if (do_push) wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/sum_byte_serializer.sv
// sum_byte_serializer: buffers 32-bit adder sums and streams them out one
// byte per cycle, least-significant byte first.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid/in_ready/in_sum      word ingress handshake
//   out_valid/out_ready/out_byte  byte egress handshake
//   out_idx                       byte position within the word (0 = LSB)
//   out_last                      marks the most-significant byte
//   busy                          FIFO non-empty or serializer active
module sum_byte_serializer
  import sum_byte_serializer_pkg::*;
#(
  parameter int DATA_W     = SBS_DATA_W,
  parameter int BYTE_W     = SBS_BYTE_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_W-1:0]                   in_sum,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [BYTE_W-1:0]                   out_byte,
  output logic [$clog2(DATA_W/BYTE_W)-1:0]    out_idx,
  output logic                                out_last,
  output logic                                busy
);

  localparam int BPW = DATA_W / BYTE_W;
  localparam int IW  = $clog2(BPW);
  localparam logic [IW-1:0] LAST_IDX = IW'(BPW - 1);

  state_e                     state_q, state_d;
  logic [DATA_W-1:0]          shreg_q, shreg_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic                       out_valid_q, out_valid_d;

  logic                       fifo_pop, fifo_empty, fifo_full;
  logic [DATA_W-1:0]          fifo_dout;
  logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count;
  logic                       hs, is_last;

  // Ready depends on registered occupancy only: no path from out_ready,
  // so a full FIFO refuses a word even when a pop happens that cycle.
  assign in_ready = !fifo_full && !rst;

  sum_word_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid && in_ready),
    .pop   (fifo_pop),
    .din   (in_sum),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign hs      = out_valid_q && out_ready;
  assign is_last = (idx_q == LAST_IDX);

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    fifo_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          shreg_d     = fifo_dout;
          idx_d       = '0;
          out_valid_d = 1'b1;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (hs) begin
          if (!is_last) begin
            shreg_d = shreg_q >> BYTE_W;
            idx_d   = idx_q + 1'b1;
          end else if (!fifo_empty) begin
            // Reload on the last byte's handshake: no bubble between words.
            fifo_pop = 1'b1;
            shreg_d  = fifo_dout;
            idx_d    = '0;
          end else begin
            out_valid_d = 1'b0;
            idx_d       = '0;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Data outputs are gated so an idle block shows zeros, not stale bytes.
  assign out_valid = out_valid_q;
  assign out_byte  = out_valid_q ? shreg_q[BYTE_W-1:0] : '0;
  assign out_idx   = out_valid_q ? idx_q : '0;
  assign out_last  = out_valid_q && is_last;
  assign busy      = (fifo_count != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_sum_byte_serializer.sv
module tb_sum_byte_serializer;

  localparam int BPW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_sum;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic [1:0]  out_idx;
  logic        out_last;
  logic        busy;

  sum_byte_serializer #(.DATA_W(32), .BYTE_W(8), .FIFO_DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_byte  (out_byte),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic [1:0] idx;
    logic       last;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: every accepted word becomes four bytes, LSB first.
  // Sampled at negedge, when inputs and outputs are settled for the next edge.
  logic       pv, pr, pl;
  logic [7:0] pb;
  logic [1:0] pi;
  initial begin
    pv = 0; pr = 0; pb = 0; pi = 0; pl = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_byte", out_byte, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        pv = 0;
      end else begin
        chk("busy_vs_model", busy, q.size() != 0);
        if (pv && !pr) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_byte", out_byte, pb);
          chk("hold_idx", out_idx, pi);
          chk("hold_last", out_last, pl);
        end
        if (out_valid) begin
          if (q.size() == 0) chk("spurious_valid", out_valid, 0);
          else begin
            chk("byte", out_byte, q[0].b);
            chk("idx", out_idx, q[0].idx);
            chk("last", out_last, q[0].last);
            if (out_ready) void'(q.pop_front());
          end
        end
        if (in_valid && in_ready)
          for (int k = 0; k < BPW; k++)
            q.push_back('{in_sum[k*8 +: 8], 2'(k), k == BPW-1});
        pv = out_valid; pr = out_ready; pb = out_byte; pi = out_idx; pl = out_last;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    int  t = 0;
    logic acc = 0;
    in_valid = 1; in_sum = w;
    while (!acc && t < 200) begin
      @(negedge clk); acc = in_ready; t++;
      step();
    end
    in_valid = 0;
    if (!acc) chk("push_timeout", 0, 1);
  endtask

  task automatic expect_byte(input string nm, input logic [7:0] b, input logic [1:0] i, input logic l);
    @(negedge clk);
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_byte"}, out_byte, b);
    chk({nm, "_idx"}, out_idx, i);
    chk({nm, "_last"}, out_last, l);
  endtask

  task automatic drain();
    int t = 0;
    out_ready = 1;
    while ((q.size() != 0 || out_valid || busy) && t < 300) begin
      @(negedge clk); t++;
    end
    if (t >= 300) chk("drain_timeout", 0, 1);
    step();
  endtask

  task automatic rand_phase(input int nwords);
    int   cnt = 0, cyc = 0;
    logic acc;
    in_valid = 0;
    while (cnt < nwords && cyc < 20000) begin
      @(negedge clk); acc = in_valid && in_ready;
      step(); cyc++;
      if (acc) begin cnt++; in_valid = 0; end
      if (!in_valid && cnt < nwords && $urandom_range(0, 3) != 0) begin
        in_valid = 1; in_sum = $urandom;
      end
      out_ready = ($urandom_range(0, 2) != 0);
    end
    in_valid = 0;
    if (cyc >= 20000) chk("rand_timeout", 0, 1);
  endtask

  logic [31:0] wsum;

  initial begin
    rst = 1; in_valid = 0; in_sum = 0; out_ready = 0;
    repeat (2) @(negedge clk);
    step(); rst = 0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_valid", out_valid, 0);
    step();

    // Single word, two-cycle latency
    out_ready = 1;
    push_word(32'h44332211);
    @(negedge clk); chk("latency_not_yet", out_valid, 0);
    expect_byte("w1b0", 8'h11, 0, 0);
    expect_byte("w1b1", 8'h22, 1, 0);
    expect_byte("w1b2", 8'h33, 2, 0);
    expect_byte("w1b3", 8'h44, 3, 1);
    @(negedge clk); chk("w1_done", out_valid, 0);
    drain();

    // Back-pressure
    out_ready = 0;
    push_word(32'hDEADBEEF);
    @(negedge clk);
    for (int i = 0; i < 5; i++) expect_byte("bp_hold", 8'hEF, 0, 0);
    step(); out_ready = 1;
    @(negedge clk);  // EF handshakes on the coming edge
    chk("bp_rel_b0", out_byte, 8'hEF);
    expect_byte("bp_b1", 8'hBE, 1, 0);
    expect_byte("bp_b2", 8'hAD, 2, 0);
    expect_byte("bp_b3", 8'hDE, 3, 1);
    drain();

    // Full FIFO: no bypass, nothing lost
    out_ready = 0;
    push_word(32'h1);
    push_word(32'h2);
    push_word(32'h3);
    @(negedge clk);
    chk("full_in_ready", in_ready, 0);
    chk("full_head_byte", out_byte, 8'h01);
    step(); out_ready = 1;
    @(negedge clk);
    chk("full_in_ready_popcycle", in_ready, 0);
    drain();

    // Gapless stream of four words
    out_ready = 1;
    fork
      begin
        push_word(32'hA3A2A1A0); push_word(32'hB3B2B1B0);
        push_word(32'hC3C2C1C0); push_word(32'hD3D2D1D0);
      end
      begin
        int w = 0, run = 0;
        while (!out_valid && w < 60) begin @(negedge clk); w++; end
        while (out_valid && run < 40) begin run++; @(negedge clk); end
        chk("gapless_run", run, 16);
      end
    join
    drain();

    // Adder wrap-around sum
    wsum = 32'hFFFFFFFF + 32'h00000001;
    push_word(wsum);
    @(negedge clk);
    expect_byte("wrap_b0", 8'h00, 0, 0);
    expect_byte("wrap_b1", 8'h00, 1, 0);
    expect_byte("wrap_b2", 8'h00, 2, 0);
    expect_byte("wrap_b3", 8'h00, 3, 1);
    drain();

    // Reset mid-word
    out_ready = 1;
    push_word(32'hCAFEF00D);
    @(negedge clk);
    expect_byte("mid_b0", 8'h0D, 0, 0);
    expect_byte("mid_b1", 8'hF0, 1, 0);
    step(); rst = 1;
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    step(); rst = 0;
    @(negedge clk);
    chk("mid_rel_busy", busy, 0);
    chk("mid_rel_in_ready", in_ready, 1);
    chk("mid_rel_valid", out_valid, 0);
    step();
    push_word(32'h12345678);
    @(negedge clk);
    expect_byte("mid_n_b0", 8'h78, 0, 0);
    expect_byte("mid_n_b1", 8'h56, 1, 0);
    expect_byte("mid_n_b2", 8'h34, 2, 0);
    expect_byte("mid_n_b3", 8'h12, 3, 1);
    drain();

    // Randomized traffic against the reference queue
    rand_phase(60);
    drain();
    chk("final_queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sum_byte_serializer.md
Name: sum_byte_serializer

Overview:
- Downstream consumer of the 32-bit byte-sliced adder: buffers completed 32-bit sums and emits them as an 8-bit stream, least-significant byte first.
- Valid/ready handshake on both sides. A small FIFO decouples adder throughput (1 word/cycle) from serial egress (1 byte/cycle).
- Sits between the adder's sum output and the byte-wide result/debug path.

Parameters:
- DATA_W, 32, input word width; must be an integer multiple of BYTE_W.
- BYTE_W, 8, output byte width, matching the adder's 8-bit slice granularity.
- FIFO_DEPTH, 2, number of buffered words; must be at least 1 and a power of 2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  in_sum holds a valid adder result.
- in_ready  out  1  block can accept a word this cycle.
- in_sum  in  DATA_W  sum word from the adder.
- out_valid  out  1  out_byte is valid.
- out_ready  in  1  sink accepts the byte this cycle.
- out_byte  out  BYTE_W  current byte.
- out_idx  out  log2(DATA_W/BYTE_W)  byte index within the word; 0 is the LSB.
- out_last  out  1  high on the final, most-significant byte of a word.
- busy  out  1  high when the FIFO is non-empty or the serializer is not IDLE.

Behaviour:
- Reset (asynchronous):
  - All FIFO pointers and count cleared to 0.
  - State goes to IDLE.
  - out_valid, out_byte, out_idx, out_last and busy all read 0.
  - in_ready = (count < FIFO_DEPTH) && !rst, so it is 0 while rst is high and 1 after release.
  - A word or byte in flight when reset asserts is dropped. No partial word is resumed after reset.
- Ingress:
  - A push happens when in_valid && in_ready at the clock edge; in_sum is written to the FIFO tail.
  - in_ready is driven from the registered count only, with no combinational path from out_ready.
  - When the FIFO is full, in_ready is 0 even if a pop occurs in the same cycle. There is no full-case bypass.
- FSM states: IDLE, SHIFT.
  - IDLE: if the FIFO is non-empty, pop the head into the shift register, set idx=0 and out_valid=1, and go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: out_byte = shreg[BYTE_W-1:0] and out_last = (idx == DATA_W/BYTE_W - 1).
  - On a handshake (out_valid && out_ready):
    - If the byte is not the last: shift right by BYTE_W and increment idx.
    - If it is the last and the FIFO is non-empty: pop and load the next word on the same edge with idx=0, staying in SHIFT. This gives no bubble between words.
    - If it is the last and the FIFO is empty: clear out_valid and go to IDLE.
- Output stability: while out_valid && !out_ready, out_byte, out_idx and out_last hold stable. out_valid never drops without a handshake.
- Simultaneous push and pop on a non-full FIFO: count is unchanged and both pointers advance. Pointers wrap modulo FIFO_DEPTH.
- Latency:
  - Word accepted at edge N into an empty, idle block: byte 0 is valid in cycle N+2, because the pop happens in cycle N+1.
  - Sustained throughput is DATA_W/BYTE_W cycles per word when out_ready is held high.
- Width rules: no arithmetic on data. Bytes are bit-exact slices, and the carry-out is not represented (the adder is modulo 2^DATA_W).

Decomposition:
- Shared package: BYTES_PER_WORD = DATA_W/BYTE_W, IDX_W = $clog2(BYTES_PER_WORD), and the state enum {IDLE, SHIFT}.
- One sub-module, sum_word_fifo: a parameterized synchronous FIFO with the same asynchronous reset, ports push/pop/din/dout/count/full/empty.
- The FSM and shift register live in the top level.

Test Plan:
- Single word: after reset, push 0x44332211 with out_ready held at 1 -> bytes 0x11, 0x22, 0x33, 0x44 with idx 0..3 and out_last only on 0x44; first valid byte 2 cycles after the push.
- Back-pressure: push 0xDEADBEEF and hold out_ready=0 for 5 cycles -> out_byte stays 0xEF, idx 0, out_valid 1; then release -> EF, BE, AD, DE.
- Full FIFO: push 0x00000001, 0x00000002, 0x00000003 back-to-back with out_ready=0 -> in_ready drops to 0 once the FIFO (2) and shift register are occupied; no word is lost; all 12 bytes come out in order.
- Gapless stream: 4 words pushed continuously with out_ready=1 -> 16 consecutive out_valid cycles with no bubble at word boundaries; pointer wrap exercised.
- Adder wrap: push the sum of 0xFFFFFFFF + 0x00000001 = 0x00000000 -> bytes 00, 00, 00, 00 with out_last on the 4th byte.
- Reset mid-word: assert rst after byte 1 of 0xCAFEF00D is accepted -> out_valid falls to 0 immediately; after release busy=0 and in_ready=1; the next push of 0x12345678 emits 78, 56, 34, 12.
